// File: rtl/controlador_partida_if.sv
// Control/status bundle between the match controller and the Pong datapath side.
interface controlador_partida_if;
  logic       iniciar;
  logic       pausa;
  logic       ponto_jogador;
  logic       ponto_adversario;
  logic       rebateu;
  logic       reseta_fd;
  logic       avanca_bola;
  logic       pausa_fd;
  logic [2:0] pontos_jogador;
  logic [2:0] pontos_adversario;
  logic       venceu_jogo;
  logic       perdeu_jogo;
  logic [2:0] db_estado;

  // Drives the requests/pulses and observes the controller outputs.
  modport master (
    output iniciar, pausa, ponto_jogador, ponto_adversario, rebateu,
    input  reseta_fd, avanca_bola, pausa_fd, pontos_jogador, pontos_adversario,
           venceu_jogo, perdeu_jogo, db_estado
  );

  // The controller itself.
  modport slave (
    input  iniciar, pausa, ponto_jogador, ponto_adversario, rebateu,
    output reseta_fd, avanca_bola, pausa_fd, pontos_jogador, pontos_adversario,
           venceu_jogo, perdeu_jogo, db_estado
  );
endinterface

// File: rtl/controlador_partida.sv
// Match-level Pong controller: start/serve/pause/end sequencing, scoring and
// the ball-step tick whose period shrinks on every paddle hit.
module controlador_partida #(
  parameter int unsigned PERIODO_INICIAL = 16,
  parameter int unsigned PERIODO_MINIMO  = 4,
  parameter int unsigned DECREMENTO      = 2,
  parameter int unsigned ESPERA_SAQUE    = 8,
  parameter int unsigned PONTOS_VITORIA  = 5,
  parameter int unsigned LARGURA_CONT    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  controlador_partida_if.slave  bus
);

  localparam int unsigned W = LARGURA_CONT;

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    PREPARA = 3'd1,
    SAQUE   = 3'd2,
    JOGANDO = 3'd3,
    PAUSADO = 3'd4,
    VENCEU  = 3'd5,
    PERDEU  = 3'd6
  } estado_t;

  estado_t        estado_q, estado_d;
  estado_t        retorno_q, retorno_d;
  logic [2:0]     pontos_j_q, pontos_j_d;
  logic [2:0]     pontos_a_q, pontos_a_d;
  logic [W-1:0]   periodo_q, periodo_d;
  logic [W-1:0]   passo_q, passo_d;
  logic [W-1:0]   saque_q, saque_d;
  logic           pausa_q;
  logic           avanca_q, avanca_d;

  logic           pausa_ev;
  logic [2:0]     pontos_j_inc;
  logic [2:0]     pontos_a_inc;

  assign pausa_ev     = bus.pausa & ~pausa_q;
  assign pontos_j_inc = pontos_j_q + 3'd1;
  assign pontos_a_inc = pontos_a_q + 3'd1;

  // State, counters, scores and the pause edge register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q   <= INICIAL;
      retorno_q  <= INICIAL;
      pontos_j_q <= 3'd0;
      pontos_a_q <= 3'd0;
      periodo_q  <= W'(PERIODO_INICIAL);
      passo_q    <= '0;
      saque_q    <= '0;
      pausa_q    <= 1'b0;
      avanca_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      retorno_q  <= retorno_d;
      pontos_j_q <= pontos_j_d;
      pontos_a_q <= pontos_a_d;
      periodo_q  <= periodo_d;
      passo_q    <= passo_d;
      saque_q    <= saque_d;
      pausa_q    <= bus.pausa;
      avanca_q   <= avanca_d;
    end
  end

  // Next-state, counter and score update.
  always_comb begin
    estado_d   = estado_q;
    retorno_d  = retorno_q;
    pontos_j_d = pontos_j_q;
    pontos_a_d = pontos_a_q;
    periodo_d  = periodo_q;
    passo_d    = passo_q;
    saque_d    = saque_q;
    avanca_d   = 1'b0;

    case (estado_q)
      INICIAL: begin
        if (bus.iniciar) begin
          estado_d   = PREPARA;
          pontos_j_d = 3'd0;
          pontos_a_d = 3'd0;
        end
      end

      PREPARA: begin
        periodo_d = W'(PERIODO_INICIAL);
        passo_d   = '0;
        saque_d   = '0;
        estado_d  = SAQUE;
      end

      SAQUE: begin
        if (pausa_ev) begin
          estado_d  = PAUSADO;
          retorno_d = SAQUE;
        end else begin
          saque_d = saque_q + W'(1);
          if (saque_q == W'(ESPERA_SAQUE - 1)) begin
            estado_d = JOGANDO;
          end
        end
      end

      JOGANDO: begin
        if (bus.ponto_jogador) begin
          pontos_j_d = pontos_j_inc;
          estado_d   = (pontos_j_inc == 3'(PONTOS_VITORIA)) ? VENCEU : PREPARA;
        end else if (bus.ponto_adversario) begin
          pontos_a_d = pontos_a_inc;
          estado_d   = (pontos_a_inc == 3'(PONTOS_VITORIA)) ? PERDEU : PREPARA;
        end else begin
          if (bus.rebateu) begin
            if (periodo_q >= W'(PERIODO_MINIMO + DECREMENTO)) begin
              periodo_d = periodo_q - W'(DECREMENTO);
            end else begin
              periodo_d = W'(PERIODO_MINIMO);
            end
          end
          if (pausa_ev) begin
            // Counter frozen here so the resumed step keeps its full remaining time.
            estado_d  = PAUSADO;
            retorno_d = JOGANDO;
          end else if (passo_q >= periodo_q - W'(1)) begin
            // >= guards against a period that shrank below the running count.
            passo_d  = '0;
            avanca_d = 1'b1;
          end else begin
            passo_d = passo_q + W'(1);
          end
        end
      end

      PAUSADO: begin
        if (pausa_ev) begin
          estado_d = retorno_q;
        end
      end

      VENCEU, PERDEU: begin
        if (bus.iniciar) begin
          estado_d   = PREPARA;
          pontos_j_d = 3'd0;
          pontos_a_d = 3'd0;
        end
      end

      default: estado_d = INICIAL;
    endcase
  end

  // Moore decode of the state register.
  assign bus.reseta_fd         = (estado_q == INICIAL) || (estado_q == PREPARA);
  assign bus.pausa_fd          = (estado_q == PAUSADO);
  assign bus.venceu_jogo       = (estado_q == VENCEU);
  assign bus.perdeu_jogo       = (estado_q == PERDEU);
  assign bus.db_estado         = estado_q;
  assign bus.avanca_bola       = avanca_q;
  assign bus.pontos_jogador    = pontos_j_q;
  assign bus.pontos_adversario = pontos_a_q;

endmodule

// File: tb/tb_controlador_partida.sv
// Directed self-checking bench for controlador_partida.
module tb_controlador_partida;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  controlador_partida_if u_if ();

  controlador_partida u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycles until the next avanca_bola pulse, bounded.
  task automatic wait_avanca(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!u_if.avanca_bola && n < 200);
  endtask

  // From a PREPARA cycle: one PREPARA + 8 SAQUE cycles, then JOGANDO.
  task automatic serve_to_play(input string tag);
    tick();
    chk({tag, "_saque"}, 32'(u_if.db_estado), 32'd2);
    repeat (8) tick();
    chk({tag, "_jogando"}, 32'(u_if.db_estado), 32'd3);
  endtask

  initial begin
    int n;
    int seen;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    u_if.iniciar = 1'b0;
    u_if.pausa = 1'b0;
    u_if.ponto_jogador = 1'b0;
    u_if.ponto_adversario = 1'b0;
    u_if.rebateu = 1'b0;

    // Reset values
    repeat (2) tick();
    chk("rst_estado", 32'(u_if.db_estado), 32'd0);
    chk("rst_reseta_fd", 32'(u_if.reseta_fd), 32'd1);
    chk("rst_pausa_fd", 32'(u_if.pausa_fd), 32'd0);
    chk("rst_avanca", 32'(u_if.avanca_bola), 32'd0);
    chk("rst_venceu", 32'(u_if.venceu_jogo), 32'd0);
    chk("rst_perdeu", 32'(u_if.perdeu_jogo), 32'd0);

    // Idle in INICIAL
    reset = 1'b1;
    repeat (10) tick();
    chk("idle_estado", 32'(u_if.db_estado), 32'd0);
    chk("idle_reseta_fd", 32'(u_if.reseta_fd), 32'd1);
    chk("idle_pj", 32'(u_if.pontos_jogador), 32'd0);
    chk("idle_pa", 32'(u_if.pontos_adversario), 32'd0);

    // Start: PREPARA 1 cycle, SAQUE 8 cycles, then JOGANDO
    u_if.iniciar = 1'b1;
    tick();
    u_if.iniciar = 1'b0;
    chk("start_prepara", 32'(u_if.db_estado), 32'd1);
    chk("start_reseta_fd", 32'(u_if.reseta_fd), 32'd1);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("start_saque", 32'(u_if.db_estado), 32'd2);
      tick();
    end
    chk("start_jogando", 32'(u_if.db_estado), 32'd3);
    chk("start_reseta_off", 32'(u_if.reseta_fd), 32'd0);

    // Default step period
    wait_avanca(n);
    chk("first_step", 32'(n), 32'd16);
    tick();
    chk("avanca_one_cycle", 32'(u_if.avanca_bola), 32'd0);
    wait_avanca(n);
    chk("second_step", 32'(n + 1), 32'd16);

    // Speed-up: one hit right after each step
    for (int i = 0; i < 7; i++) begin
      int expp;
      expp = (16 - 2 * (i + 1) < 4) ? 4 : 16 - 2 * (i + 1);
      u_if.rebateu = 1'b1;
      tick();
      u_if.rebateu = 1'b0;
      wait_avanca(n);
      chk("hit_period", 32'(n + 1), 32'(expp));
    end
    wait_avanca(n);
    chk("floor_period", 32'(n), 32'd4);

    // Opponent point, new serve restores 16
    u_if.ponto_adversario = 1'b1;
    tick();
    u_if.ponto_adversario = 1'b0;
    chk("pa_prepara", 32'(u_if.db_estado), 32'd1);
    chk("pa_score", 32'(u_if.pontos_adversario), 32'd1);
    chk("pa_no_avanca", 32'(u_if.avanca_bola), 32'd0);
    serve_to_play("serve1");
    wait_avanca(n);
    chk("restored_period", 32'(n), 32'd16);

    // Pause at step 5, held for 50 cycles
    repeat (5) tick();
    u_if.pausa = 1'b1;
    tick();
    chk("pause_estado", 32'(u_if.db_estado), 32'd4);
    chk("pause_fd", 32'(u_if.pausa_fd), 32'd1);
    seen = 0;
    u_if.ponto_jogador = 1'b1;
    tick();
    u_if.ponto_jogador = 1'b0;
    for (int i = 0; i < 49; i++) begin
      if (u_if.avanca_bola) seen++;
      tick();
    end
    chk("pause_no_avanca", 32'(seen), 32'd0);
    chk("pause_held_estado", 32'(u_if.db_estado), 32'd4);
    chk("pause_pj_ignored", 32'(u_if.pontos_jogador), 32'd0);
    u_if.pausa = 1'b0;
    tick();
    u_if.pausa = 1'b1;
    tick();
    u_if.pausa = 1'b0;
    chk("resume_estado", 32'(u_if.db_estado), 32'd3);
    chk("resume_fd", 32'(u_if.pausa_fd), 32'd0);
    wait_avanca(n);
    chk("resume_step", 32'(n), 32'd11);

    // Simultaneous: both points and hit
    tick();
    u_if.ponto_jogador = 1'b1;
    u_if.ponto_adversario = 1'b1;
    u_if.rebateu = 1'b1;
    tick();
    u_if.ponto_jogador = 1'b0;
    u_if.ponto_adversario = 1'b0;
    u_if.rebateu = 1'b0;
    chk("simul_pj", 32'(u_if.pontos_jogador), 32'd1);
    chk("simul_pa", 32'(u_if.pontos_adversario), 32'd1);
    chk("simul_estado", 32'(u_if.db_estado), 32'd1);

    // Player scores to 5
    for (int k = 2; k <= 5; k++) begin
      serve_to_play("win_serve");
      tick();
      u_if.ponto_jogador = 1'b1;
      tick();
      u_if.ponto_jogador = 1'b0;
      chk("win_pj", 32'(u_if.pontos_jogador), 32'(k));
      if (k < 5) chk("win_prepara", 32'(u_if.db_estado), 32'd1);
    end
    chk("win_estado", 32'(u_if.db_estado), 32'd5);
    chk("win_venceu", 32'(u_if.venceu_jogo), 32'd1);
    chk("win_perdeu", 32'(u_if.perdeu_jogo), 32'd0);
    repeat (4) tick();
    chk("win_hold_pj", 32'(u_if.pontos_jogador), 32'd5);
    chk("win_hold_estado", 32'(u_if.db_estado), 32'd5);

    // Restart from VENCEU
    u_if.iniciar = 1'b1;
    tick();
    u_if.iniciar = 1'b0;
    chk("restart_estado", 32'(u_if.db_estado), 32'd1);
    chk("restart_pj", 32'(u_if.pontos_jogador), 32'd0);
    chk("restart_pa", 32'(u_if.pontos_adversario), 32'd0);

    // Score then asynchronous reset mid-JOGANDO
    serve_to_play("rst_serve");
    u_if.ponto_jogador = 1'b1;
    tick();
    u_if.ponto_jogador = 1'b0;
    chk("pre_rst_pj", 32'(u_if.pontos_jogador), 32'd1);
    serve_to_play("rst_serve2");
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_estado", 32'(u_if.db_estado), 32'd0);
    chk("arst_reseta_fd", 32'(u_if.reseta_fd), 32'd1);
    chk("arst_pj", 32'(u_if.pontos_jogador), 32'd0);
    chk("arst_avanca", 32'(u_if.avanca_bola), 32'd0);
    chk("arst_pausa_fd", 32'(u_if.pausa_fd), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
